// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use / RAW detection against EX and MEM rd shadows,
// stall/flush/freeze pipeline controls, registered forwarding selects and a saturating stall counter.
module id_hazard_ctrl #(
  parameter int ENABLE_FWD = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             ex_taken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_t;

  logic [6:0] opcode_s;
  logic [4:0] rd_s, rs1_s, rs2_s;
  logic       uses_rs1_s, uses_rs2_s, writes_s, is_load_s, wr_s;
  logic       ldhaz_s, rawhaz_s;
  logic [1:0] fwd_a_nxt_s, fwd_b_nxt_s;
  state_t     state_s;
  logic       unused_bits_s;

  logic       ex_v_r, ex_ld_r, mem_v_r;
  logic [4:0] ex_rd_r, mem_rd_r;
  logic [1:0] fwd_a_r, fwd_b_r;
  logic [CNT_W-1:0] stall_cnt_r;

  assign opcode_s      = id_inst[6:0];
  assign rd_s          = id_inst[11:7];
  assign rs1_s         = id_inst[19:15];
  assign rs2_s         = id_inst[24:20];
  assign unused_bits_s = ^{id_inst[31:25], id_inst[14:12]};
  assign wr_s          = writes_s & (rd_s != 5'd0);

  // EX-stage priority over MEM; an unused source or a load in EX never forwards
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input logic exv, input logic [4:0] exrd, input logic exld,
                                         input logic memv, input logic [4:0] memrd);
    if (!used)                             fwd_sel = 2'b00;
    else if (exv && exrd == rs && !exld)   fwd_sel = 2'b01;
    else if (memv && memrd == rs)          fwd_sel = 2'b10;
    else                                   fwd_sel = 2'b00;
  endfunction

  // Register-usage decode of the ID instruction
  always_comb begin
    uses_rs1_s = 1'b0;
    uses_rs2_s = 1'b0;
    writes_s   = 1'b0;
    is_load_s  = 1'b0;
    if (id_valid) begin
      case (opcode_s)
        OPC_LUI, OPC_AUIPC, OPC_JAL: writes_s = 1'b1;
        OPC_JALR, OPC_IMM: begin
          uses_rs1_s = 1'b1;
          writes_s   = 1'b1;
        end
        OPC_LOAD: begin
          uses_rs1_s = 1'b1;
          writes_s   = 1'b1;
          is_load_s  = 1'b1;
        end
        OPC_OP: begin
          uses_rs1_s = 1'b1;
          uses_rs2_s = 1'b1;
          writes_s   = 1'b1;
        end
        OPC_STORE, OPC_BRANCH: begin
          uses_rs1_s = 1'b1;
          uses_rs2_s = 1'b1;
        end
        default: begin
          uses_rs1_s = 1'b0;
          uses_rs2_s = 1'b0;
        end
      endcase
    end else begin
      writes_s = 1'b0;
    end
  end

  // Hazard detection and the per-cycle priority decision
  always_comb begin
    ldhaz_s  = ex_v_r && ex_ld_r &&
               ((uses_rs1_s && ex_rd_r == rs1_s) || (uses_rs2_s && ex_rd_r == rs2_s));
    rawhaz_s = (ENABLE_FWD == 0) &&
               ((ex_v_r  && ((uses_rs1_s && ex_rd_r  == rs1_s) || (uses_rs2_s && ex_rd_r  == rs2_s))) ||
                (mem_v_r && ((uses_rs1_s && mem_rd_r == rs1_s) || (uses_rs2_s && mem_rd_r == rs2_s))));
    if (mem_busy)               state_s = ST_FREEZE;
    else if (ex_taken)          state_s = ST_FLUSH;
    else if (ldhaz_s || rawhaz_s) state_s = ST_STALL;
    else                        state_s = ST_RUN;
  end

  // Forwarding selects for the instruction about to enter EX
  always_comb begin
    if (ENABLE_FWD != 0 && state_s == ST_RUN) begin
      fwd_a_nxt_s = fwd_sel(uses_rs1_s, rs1_s, ex_v_r, ex_rd_r, ex_ld_r, mem_v_r, mem_rd_r);
      fwd_b_nxt_s = fwd_sel(uses_rs2_s, rs2_s, ex_v_r, ex_rd_r, ex_ld_r, mem_v_r, mem_rd_r);
    end else begin
      fwd_a_nxt_s = 2'b00;
      fwd_b_nxt_s = 2'b00;
    end
  end

  // Control outputs follow the current decision; reset forces them low asynchronously
  assign pc_hold      = rst_n & ((state_s == ST_FREEZE) | (state_s == ST_STALL));
  assign if_id_hold   = rst_n & ((state_s == ST_FREEZE) | (state_s == ST_STALL));
  assign pipe_freeze  = rst_n & (state_s == ST_FREEZE);
  assign if_id_flush  = rst_n & (state_s == ST_FLUSH);
  assign id_ex_bubble = rst_n & ((state_s == ST_FLUSH) | (state_s == ST_STALL));
  assign fwd_a        = fwd_a_r;
  assign fwd_b        = fwd_b_r;
  assign stall_cnt    = stall_cnt_r;

  // Shadow pipeline, forwarding registers and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_r      <= 1'b0;
      ex_ld_r     <= 1'b0;
      ex_rd_r     <= 5'd0;
      mem_v_r     <= 1'b0;
      mem_rd_r    <= 5'd0;
      fwd_a_r     <= 2'b00;
      fwd_b_r     <= 2'b00;
      stall_cnt_r <= '0;
    end else begin
      if (state_s != ST_FREEZE) begin
        mem_v_r  <= ex_v_r;
        mem_rd_r <= ex_rd_r;
        fwd_a_r  <= fwd_a_nxt_s;
        fwd_b_r  <= fwd_b_nxt_s;
        if (state_s == ST_RUN) begin
          ex_v_r  <= wr_s;
          ex_rd_r <= rd_s;
          ex_ld_r <= is_load_s;
        end else begin
          ex_v_r  <= 1'b0;
          ex_rd_r <= 5'd0;
          ex_ld_r <= 1'b0;
        end
      end else begin
        mem_v_r <= mem_v_r;
      end
      if (state_s == ST_STALL && stall_cnt_r != {CNT_W{1'b1}}) begin
        stall_cnt_r <= stall_cnt_r + 1'b1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule
